lagd_mem_bank_arbiter: RTL

Per-bank arbiter for the L2, stack and Ising-core L1 memories. It shares one single-ported SRAM bank between NumNarrowReq narrow requesters and one wide-slice requester. Wide has priority, with bounded narrow starvation (WidePriorityWait), and round-robin applies among the narrow ports. It tracks in-flight reads across BankAccessLatency cycles and routes each read response back to its issuer. Instantiated once per bank inside the memory subsystem, parameterised from a mem_cfg_t.

---
 rtl/lagd_mem_pkg.sv | 37 +++
 rtl/lagd_mem_rsp_tracker.sv | 50 +++++
 rtl/lagd_mem_bank_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lagd_mem_pkg.sv
// Shared types and configuration helpers for the LAGD memory subsystem.
package lagd_mem_pkg;

    localparam int unsigned MAX_NUM_NARROW_REQ = 32;
    localparam int unsigned TagIdxWidth        = $clog2(MAX_NUM_NARROW_REQ);

    // One in-flight read: which requester gets the response.
    typedef struct packed {
        logic                   valid;
        logic                   is_wide;
        logic [TagIdxWidth-1:0] idx;
    } bank_tag_t;

    // Memory-subsystem level configuration.
    typedef struct packed {
        int unsigned words_per_bank;
        int unsigned num_narrow_req;
        int unsigned bank_access_latency;
        int unsigned wide_priority_wait;
    } mem_cfg_t;

    // Per-bank arbiter parameters derived from a mem_cfg_t.
    typedef struct packed {
        int unsigned num_narrow_req;
        int unsigned addr_width;
        int unsigned latency;
    } bank_arb_cfg_t;

    function automatic bank_arb_cfg_t bank_arb_cfg(input mem_cfg_t cfg);
        bank_arb_cfg_t res;
        res.num_narrow_req = cfg.num_narrow_req;
        res.addr_width     = (cfg.words_per_bank > 1) ? $clog2(cfg.words_per_bank) : 1;
        res.latency        = (cfg.bank_access_latency > 0) ? cfg.bank_access_latency : 1;
        return res;
    endfunction

endpackage

// File: rtl/lagd_mem_rsp_tracker.sv
// Tag shift register following each bank access; the tail stage raises the
// read-valid of the requester that issued the read.
module lagd_mem_rsp_tracker
    import lagd_mem_pkg::*;
#(
    parameter int unsigned Depth    = 1,
    parameter int unsigned NumPorts = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_valid_i,
    input  logic                   push_is_wide_i,
    input  logic [TagIdxWidth-1:0] push_idx_i,
    output logic                   wide_rvalid_o,
    output logic [NumPorts-1:0]    narrow_rvalid_o
);

    bank_tag_t [Depth-1:0] stage_q, stage_d;
    bank_tag_t             tail;

    // Shift tags one stage per cycle; stage 0 takes the current grant.
    always_comb begin
        stage_d         = stage_q;
        stage_d[0]      = '{valid: push_valid_i, is_wide: push_is_wide_i, idx: push_idx_i};
        for (int unsigned k = 1; k < Depth; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Reset drops every in-flight response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Demux the tail tag onto exactly one rvalid; silent while in reset.
    always_comb begin
        tail            = stage_q[Depth-1];
        wide_rvalid_o   = !rst_i && tail.valid && tail.is_wide;
        narrow_rvalid_o = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            narrow_rvalid_o[p] = !rst_i && tail.valid && !tail.is_wide &&
                                 (tail.idx == TagIdxWidth'(p));
        end
    end

endmodule

// File: rtl/lagd_mem_bank_arbiter.sv
// Per-bank arbiter: one wide requester with bounded priority over
// round-robin narrow requesters, sharing a single-ported SRAM bank.
module lagd_mem_bank_arbiter
    import lagd_mem_pkg::*;
#(
    parameter int unsigned NumNarrowReq      = 4,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned AddrWidth         = 11,
    parameter int unsigned WidePriorityWait  = 4,
    parameter int unsigned BankAccessLatency = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumNarrowReq-1:0]             narrow_req_i,
    input  logic [NumNarrowReq-1:0]             narrow_we_i,
    input  logic [NumNarrowReq*AddrWidth-1:0]   narrow_addr_i,
    input  logic [NumNarrowReq*DataWidth-1:0]   narrow_wdata_i,
    input  logic [NumNarrowReq*DataWidth/8-1:0] narrow_be_i,
    output logic [NumNarrowReq-1:0]             narrow_gnt_o,
    output logic [NumNarrowReq-1:0]             narrow_rvalid_o,
    output logic [DataWidth-1:0]                narrow_rdata_o,
    input  logic                                wide_req_i,
    input  logic                                wide_we_i,
    input  logic [AddrWidth-1:0]                wide_addr_i,
    input  logic [DataWidth-1:0]                wide_wdata_i,
    input  logic [DataWidth/8-1:0]              wide_be_i,
    output logic                                wide_gnt_o,
    output logic                                wide_rvalid_o,
    output logic [DataWidth-1:0]                wide_rdata_o,
    output logic                                bank_req_o,
    output logic                                bank_we_o,
    output logic [AddrWidth-1:0]                bank_addr_o,
    output logic [DataWidth-1:0]                bank_wdata_o,
    output logic [DataWidth/8-1:0]              bank_be_o,
    input  logic [DataWidth-1:0]                bank_rdata_i
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned PtrWidth = (NumNarrowReq > 1) ? $clog2(NumNarrowReq) : 1;
    localparam int unsigned CntWidth = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;
    localparam logic [CntWidth-1:0] CntMax  = CntWidth'(WidePriorityWait);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(NumNarrowReq - 1);

    logic [PtrWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;
    logic [PtrWidth-1:0] winner;
    logic [PtrWidth-1:0] cand;
    logic                winner_found;
    logic                any_narrow;
    logic                force_narrow;
    logic                wide_gnt;
    logic                narrow_gnt;

    // Round-robin pick: first requesting port at or after rr_ptr, wrapping.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int unsigned i = 0; i < NumNarrowReq; i++) begin
            cand = PtrWidth'((32'(rr_ptr_q) + i) % NumNarrowReq);
            if (!winner_found && narrow_req_i[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Wide wins unless narrow has been stalled WidePriorityWait wide grants in a row.
    always_comb begin
        any_narrow   = |narrow_req_i;
        force_narrow = (WidePriorityWait != 0) && (starve_cnt_q == CntMax) && any_narrow;
        wide_gnt     = !rst_i && wide_req_i && !force_narrow;
        narrow_gnt   = !rst_i && any_narrow && !wide_gnt;
        wide_gnt_o   = wide_gnt;
        narrow_gnt_o = narrow_gnt ? (NumNarrowReq'(1) << winner) : '0;
    end

    // Bank payload from the granted port; all zero when idle.
    always_comb begin
        bank_req_o   = wide_gnt || narrow_gnt;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (wide_gnt) begin
            bank_we_o    = wide_we_i;
            bank_addr_o  = wide_addr_i;
            bank_wdata_o = wide_wdata_i;
            bank_be_o    = wide_be_i;
        end else if (narrow_gnt) begin
            bank_we_o    = narrow_we_i[winner];
            bank_addr_o  = narrow_addr_i[winner*AddrWidth +: AddrWidth];
            bank_wdata_o = narrow_wdata_i[winner*DataWidth +: DataWidth];
            bank_be_o    = narrow_be_i[winner*BeWidth +: BeWidth];
        end
    end

    // Next round-robin pointer and starvation count.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        if (narrow_gnt) begin
            rr_ptr_d = (winner == PtrLast) ? '0 : winner + 1'b1;
        end
        if (wide_gnt && any_narrow) begin
            starve_cnt_d = (starve_cnt_q == CntMax) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end else if (narrow_gnt || !any_narrow) begin
            starve_cnt_d = '0;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    lagd_mem_rsp_tracker #(
        .Depth    (BankAccessLatency),
        .NumPorts (NumNarrowReq)
    ) u_rsp_tracker (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .push_valid_i    (bank_req_o && !bank_we_o),
        .push_is_wide_i  (wide_gnt),
        .push_idx_i      (TagIdxWidth'(winner)),
        .wide_rvalid_o   (wide_rvalid_o),
        .narrow_rvalid_o (narrow_rvalid_o)
    );

    assign narrow_rdata_o = bank_rdata_i;
    assign wide_rdata_o   = bank_rdata_i;

endmodule
